instr_mem_loader: RTL
=====================

# instr_mem_loader

Byte-stream program loader that writes the processor's instruction memory, the write side of the memory the core fetches from. Accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes little-endian into `WIDTH`-bit words and issues one memory write per word. Holds the core in reset until the image is complete. Sits between the host link and the instruction RAM's write port and drives the core's reset.

## Interface
- `WIDTH`, 32: instruction word width in bits; must be a multiple of 8.
- `DEPTH`, 256: instruction memory depth in words; maximum 256.
- `ADR_WIDTH`, `$clog2(DEPTH)`: word address width.

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `byte_valid`  in  1: `byte_data` is valid.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `mem_we`  out  1: instruction memory write enable, one-cycle pulse per word.
- `mem_addr`  out  `ADR_WIDTH`: word address of the write.
- `mem_wdata`  out  `WIDTH`: word written.
- `cpu_rst`  out  1: core reset, active high.
- `done`  out  1: image loaded successfully.
- `err`  out  1: load aborted.

## Operation
- Byte transfer occurs on a rising edge with `byte_valid && byte_ready`. No transfer occurs otherwise. `byte_data` is ignored when no transfer occurs.
- Stream format: one length byte L, where the word count is N = L+1. Then N×(WIDTH/8) payload bytes. Then, with `LOADER_CHECKSUM_EN` only, one checksum byte.
- State machine: `S_LEN` → `S_DATA` → (`S_CSUM`) → `S_FIN` → `S_DONE`. `S_ERR` is terminal. Leaving `S_DONE` or `S_ERR` requires `rst`.
- `S_LEN`: on the length byte transfer, if L ≥ `DEPTH`, go to `S_ERR`. Otherwise latch N−1, clear the word address and byte counter, and go to `S_DATA`.
- `S_DATA`: byte k of a word goes to bits [8k+7:8k] of the word. The first byte is the least significant.
  - On transfer of the last byte of a word, register `mem_wdata`, `mem_addr` and `mem_we=1` for the next cycle.
  - Then increment the word address.
  - After word N−1, go to `S_CSUM` if checksum is enabled, else `S_FIN`.
- `S_FIN`: one cycle that covers the final `mem_we` pulse. Then go to `S_DONE`.
- `S_DONE`: `done=1`, `cpu_rst=0`, `byte_ready=0`.
- `S_ERR`: `err=1`, `cpu_rst=1`, `byte_ready=0`. Writes already issued are not undone.
- `byte_ready=1` exactly in `S_LEN`, `S_DATA` and `S_CSUM`.
- `cpu_rst=1` in every state except `S_DONE`.
- Word address never wraps within a load. N = `DEPTH` writes addresses 0..`DEPTH`−1 exactly once.

## Timing
- Reset values, asserted asynchronously:
  - State `S_LEN`.
  - `cpu_rst=1`, `byte_ready=1`.
  - `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `done=0`, `err=0`.
- Write latency: `mem_we` is high in the cycle after the edge that accepts a word's last byte. `mem_addr` and `mem_wdata` are valid in that same cycle. Between writes, `mem_addr` and `mem_wdata` hold their last values.
- Full-rate input (`byte_valid` constantly high) is sustained with no bubbles. The minimum spacing between `mem_we` pulses is WIDTH/8 cycles.
- Gaps in `byte_valid` stall the loader with no state change.
- No checksum: the final `mem_we` is high in `S_FIN`. `done` rises and `cpu_rst` falls on the following edge.
- Reset asserted mid-load drops `mem_we` immediately and discards the partial word. A fresh load starts from `S_LEN`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Checksum = XOR of all payload bytes, excluding the length byte.
  - After the last word, the loader expects one checksum byte in `S_CSUM`.
  - On match, go to `S_DONE` on the next edge. This edge follows the final `mem_we` cycle, so `S_FIN` is merged in.
  - On mismatch, go to `S_ERR`.
- Undefined: no checksum byte is accepted and `S_CSUM` is absent. The byte following the last payload byte is not accepted (`byte_ready=0`).

## Test plan
- Single-word load, WIDTH=32: bytes 0x00, 0x78, 0x56, 0x34, 0x12 → one `mem_we` with `mem_addr=0`, `mem_wdata=0x12345678`. Then `done=1` and `cpu_rst=0` two cycles after the last byte.
- Full image, DEPTH=256: L=0xFF followed by 1024 bytes of an incrementing pattern → 256 pulses at addresses 0..255, correct words, no repeated address, `done=1`.
- Length overflow, DEPTH=16: L=0x10 → `err=1`, `byte_ready=0`, `cpu_rst=1`, no `mem_we` ever.
- Stalls: L=1 with `byte_valid` toggling randomly → same two words as a gapless run. `byte_ready` stays high until the last byte is accepted.
- Reset mid-word after 2 bytes of word 3 → outputs return to reset values asynchronously. A following clean 1-word load writes address 0 correctly.
- `LOADER_CHECKSUM_EN`: payload 0x11, 0x22, 0x33, 0x44 with checksum 0x44 → `done=1`. With checksum 0x45 → `err=1` and `cpu_rst=1`, while the `mem_we` for the word still occurred.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// slave = loader side, master = host link / memory side.
interface instr_mem_loader_if #(
  parameter int WIDTH     = 32,
  parameter int ADR_WIDTH = 8
);
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 mem_we;
  logic [ADR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Length-prefixed byte-stream loader for the instruction RAM; holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 256,
  parameter int ADR_WIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  instr_mem_loader_if.slave bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  // state  | meaning
  // S_LEN  | waiting for length byte L (word count L+1)
  // S_DATA | packing payload bytes little-endian, one write per word
  // S_CSUM | waiting for checksum byte (checksum build only)
  // S_FIN  | final write pulse in flight
  // S_DONE | image loaded, core released
  // S_ERR  | load aborted, core held in reset

  localparam int BYTES = WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_LEN, S_DATA, S_CSUM, S_FIN, S_DONE, S_ERR
  } state_t;

  state_t               state;
  logic [ADR_WIDTH-1:0] word_last;
  logic [ADR_WIDTH-1:0] word_addr;
  logic [BCW-1:0]       byte_cnt;
  logic [WIDTH-1:0]     word_buf;
  logic [WIDTH-1:0]     word_next;
  logic                 xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign xfer = bus.byte_valid && bus.byte_ready;

  always_comb begin
    word_next = word_buf;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_cnt == BCW'(k)) word_next[8*k +: 8] = bus.byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_LEN;
      cpu_rst        <= 1'b1;
      bus.byte_ready <= 1'b1;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      word_last      <= '0;
      word_addr      <= '0;
      byte_cnt       <= '0;
      word_buf       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_LEN: begin
          if (xfer) begin
            if (32'(bus.byte_data) >= DEPTH) begin
              state          <= S_ERR;
              err            <= 1'b1;
              bus.byte_ready <= 1'b0;
            end else begin
              word_last <= bus.byte_data[ADR_WIDTH-1:0];
              word_addr <= '0;
              byte_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
              csum      <= '0;
`endif
              state     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_buf <= word_next;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.byte_data;
`endif
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt      <= '0;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_addr;
              bus.mem_wdata <= word_next;
              // Address is held on the last word so a full-depth load never wraps.
              if (word_addr == word_last) begin
`ifdef LOADER_CHECKSUM_EN
                state          <= S_CSUM;
`else
                state          <= S_FIN;
                bus.byte_ready <= 1'b0;
`endif
              end else begin
                word_addr <= word_addr + ADR_WIDTH'(1);
              end
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            bus.byte_ready <= 1'b0;
            if (bus.byte_data == csum) begin
              state   <= S_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        S_FIN: begin
          state   <= S_DONE;
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end
endmodule
